// File: rtl/counter_seq_decoder.sv
// Recovers up/down/hold/reset control from an observed counter value stream.
// Latency: one cycle, every output is registered from the sample at the previous edge.
// No backpressure: a sample is consumed on every cycle valid_i is high.
module counter_seq_decoder #(
    parameter int WIDTH         = 4,
    parameter int RUN_W         = 8,
    parameter int LOCK_N        = 4,
    parameter int ZERO_IS_RESET = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             valid_i,
    input  logic             err_clr_i,
    output logic             dir_o,
    output logic             moving_o,
    output logic             locked_o,
    output logic [RUN_W-1:0] run_len_o,
    output logic             wrap_o,
    output logic             rst_seen_o,
    output logic             err_o,
    output logic [7:0]       err_cnt_o
);

    localparam logic [1:0] ST_ACQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [WIDTH-1:0] MAX_V    = '1;
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [7:0]       LOCK_MAX = 8'(LOCK_N);
    localparam logic [7:0]       ERR_MAX  = 8'hff;

    logic [1:0]       state;
    logic [1:0]       nxt_state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta;
    logic [7:0]       lock_cnt;
    logic [7:0]       lock_nxt;
    logic [RUN_W-1:0] run_nxt;
    logic             legal;
    logic             bad;
    logic             rst_hit;
    logic             wrap_hit;

    assign delta = d_i - prev;

    // Classification priority: hold, up step, down step, reset-to-zero, illegal.
    always_comb begin
        nxt_state = state;
        legal     = 1'b0;
        bad       = 1'b0;
        rst_hit   = 1'b0;
        wrap_hit  = 1'b0;
        if (state == ST_ACQ) begin
            nxt_state = ST_HOLD;
        end else if (delta == '0) begin
            nxt_state = ST_HOLD;
            legal     = 1'b1;
        end else if (delta == ONE_V) begin
            nxt_state = ST_UP;
            legal     = 1'b1;
            wrap_hit  = (prev == MAX_V);
        end else if (delta == MAX_V) begin
            nxt_state = ST_DOWN;
            legal     = 1'b1;
            wrap_hit  = (prev == '0);
        end else if (d_i == '0 && ZERO_IS_RESET != 0) begin
            nxt_state = ST_HOLD;
            rst_hit   = 1'b1;
        end else begin
            nxt_state = ST_HOLD;
            bad       = 1'b1;
        end
    end

    always_comb begin
        lock_nxt = lock_cnt;
        if (rst_hit || bad) begin
            lock_nxt = '0;
        end else if (legal && lock_cnt != LOCK_MAX) begin
            lock_nxt = lock_cnt + 8'd1;
        end
    end

    always_comb begin
        run_nxt = RUN_W'(1);
        if (legal && nxt_state == state) begin
            run_nxt = (run_len_o == RUN_MAX) ? run_len_o : run_len_o + RUN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_ACQ;
            prev       <= '0;
            lock_cnt   <= '0;
            dir_o      <= 1'b0;
            moving_o   <= 1'b0;
            locked_o   <= 1'b0;
            run_len_o  <= '0;
            wrap_o     <= 1'b0;
            rst_seen_o <= 1'b0;
        end else begin
            wrap_o     <= 1'b0;
            rst_seen_o <= 1'b0;
            if (valid_i) begin
                state      <= nxt_state;
                prev       <= d_i;
                lock_cnt   <= lock_nxt;
                locked_o   <= (lock_nxt == LOCK_MAX);
                run_len_o  <= run_nxt;
                wrap_o     <= wrap_hit;
                rst_seen_o <= rst_hit;
                moving_o   <= legal && (nxt_state != ST_HOLD);
                if (legal && nxt_state == ST_UP) begin
                    dir_o <= 1'b1;
                end else if (legal && nxt_state == ST_DOWN) begin
                    dir_o <= 1'b0;
                end
            end
        end
    end

    // A jump in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (valid_i && bad) begin
            err_o     <= 1'b1;
            err_cnt_o <= err_clr_i ? 8'd1 :
                         (err_cnt_o == ERR_MAX) ? err_cnt_o : err_cnt_o + 8'd1;
        end else if (err_clr_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_counter_seq_decoder.sv
// Bench: two decoders (reset-to-zero classification on and off) against a behavioural model.
module tb_counter_seq_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic       valid;
    logic       clr;

    logic       dir_w    [2];
    logic       mov_w    [2];
    logic       lock_w   [2];
    logic [7:0] run_w    [2];
    logic       wrap_w   [2];
    logic       rseen_w  [2];
    logic       err_w    [2];
    logic [7:0] ecnt_w   [2];

    int checks   = 0;
    int failures = 0;

    counter_seq_decoder #(.WIDTH(4), .RUN_W(8), .LOCK_N(4), .ZERO_IS_RESET(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .d_i(d), .valid_i(valid), .err_clr_i(clr),
        .dir_o(dir_w[0]), .moving_o(mov_w[0]), .locked_o(lock_w[0]), .run_len_o(run_w[0]),
        .wrap_o(wrap_w[0]), .rst_seen_o(rseen_w[0]), .err_o(err_w[0]), .err_cnt_o(ecnt_w[0])
    );

    counter_seq_decoder #(.WIDTH(4), .RUN_W(8), .LOCK_N(4), .ZERO_IS_RESET(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .d_i(d), .valid_i(valid), .err_clr_i(clr),
        .dir_o(dir_w[1]), .moving_o(mov_w[1]), .locked_o(lock_w[1]), .run_len_o(run_w[1]),
        .wrap_o(wrap_w[1]), .rst_seen_o(rseen_w[1]), .err_o(err_w[1]), .err_cnt_o(ecnt_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: kind 0 hold, 1 up, 2 down, 3 zero reset, 4 jump, 5 first sample.
    // mode 0 acquiring, 1 hold, 2 up, 3 down.
    int m_acq [2], m_prev [2], m_mode [2], m_run [2], m_lock [2];
    int m_dir [2], m_mov [2], m_wrap [2], m_rst [2], m_err [2], m_cnt [2];
    int kind, del, nmode;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_acq[k] <= 0; m_prev[k] <= 0; m_mode[k] <= 0; m_run[k] <= 0;
                m_lock[k] <= 0; m_dir[k] <= 0; m_mov[k] <= 0; m_wrap[k] <= 0;
                m_rst[k] <= 0; m_err[k] <= 0; m_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_wrap[k] <= 0;
                m_rst[k]  <= 0;
                kind = 6;
                if (valid) begin
                    del = (int'(d) - m_prev[k] + 16) % 16;
                    if (m_acq[k] == 0)            kind = 5;
                    else if (del == 0)            kind = 0;
                    else if (del == 1)            kind = 1;
                    else if (del == 15)           kind = 2;
                    else if (d == 0 && k == 0)    kind = 3;
                    else                          kind = 4;
                    nmode = (kind == 1) ? 2 : (kind == 2) ? 3 : 1;
                    m_acq[k]  <= 1;
                    m_prev[k] <= int'(d);
                    m_mode[k] <= nmode;
                    if (kind <= 2) begin
                        m_run[k]  <= (nmode == m_mode[k]) ? ((m_run[k] < 255) ? m_run[k] + 1 : 255) : 1;
                        m_lock[k] <= (m_lock[k] < 4) ? m_lock[k] + 1 : 4;
                    end else begin
                        m_run[k] <= 1;
                        if (kind != 5) m_lock[k] <= 0;
                    end
                    m_mov[k]  <= (kind == 1 || kind == 2) ? 1 : 0;
                    if (kind == 1) m_dir[k] <= 1;
                    if (kind == 2) m_dir[k] <= 0;
                    m_wrap[k] <= ((kind == 1 && m_prev[k] == 15) || (kind == 2 && m_prev[k] == 0)) ? 1 : 0;
                    m_rst[k]  <= (kind == 3) ? 1 : 0;
                end
                if (kind == 4) begin
                    m_err[k] <= 1;
                    m_cnt[k] <= clr ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
                end else if (clr) begin
                    m_err[k] <= 0;
                    m_cnt[k] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("dir",      k, int'(dir_w[k]),   m_dir[k]);
            chk("moving",   k, int'(mov_w[k]),   m_mov[k]);
            chk("locked",   k, int'(lock_w[k]),  (m_lock[k] == 4) ? 1 : 0);
            chk("run_len",  k, int'(run_w[k]),   m_run[k]);
            chk("wrap",     k, int'(wrap_w[k]),  m_wrap[k]);
            chk("rst_seen", k, int'(rseen_w[k]), m_rst[k]);
            chk("err",      k, int'(err_w[k]),   m_err[k]);
            chk("err_cnt",  k, int'(ecnt_w[k]),  m_cnt[k]);
        end
    end

    // Inputs change 1ns after the rising edge; returns once outputs have updated.
    task automatic step(input logic v, input logic [3:0] dv, input logic c);
        valid = v;
        d     = dv;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; outputs must drop without a clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("async_run", 0, int'(run_w[0]), 0);
        chk("async_ecnt", 1, int'(ecnt_w[1]), 0);
        chk("async_dir", 0, int'(dir_w[0]), 0);
        #2 rst = 1'b0;
        valid = 1'b0;
        clr   = 1'b0;
    endtask

    int wraps;
    int up_seq [18];
    int dn_seq [6] = '{3, 2, 1, 0, 15, 14};
    int hold_run [5] = '{1, 1, 1, 2, 3};
    logic [3:0] last_d;

    initial begin
        rst = 1'b1; valid = 1'b0; d = '0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_run", 0, int'(run_w[0]), 0);
        chk("reset_locked", 0, int'(lock_w[0]), 0);
        chk("reset_err", 0, int'(err_w[0]), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Up ramp with wrap.
        for (int i = 0; i < 18; i++) up_seq[i] = i % 16;
        wraps = 0;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 4'(up_seq[i]), 1'b0);
            wraps += int'(wrap_w[0]);
            if (i == 3) chk("lock_not_yet", 0, int'(lock_w[0]), 0);
            if (i == 4) chk("lock_5th", 0, int'(lock_w[0]), 1);
            if (i == 16) chk("wrap_at_0", 0, int'(wrap_w[0]), 1);
        end
        chk("up_wraps", 0, wraps, 1);
        chk("up_run17", 0, int'(run_w[0]), 17);
        chk("up_dir", 0, int'(dir_w[0]), 1);
        chk("up_err", 0, int'(err_w[0]), 0);

        // Hold after one up step.
        async_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 0) ? 4'd5 : 4'd6, 1'b0);
            chk("hold_run", 0, int'(run_w[0]), hold_run[i]);
        end
        chk("hold_dir", 0, int'(dir_w[0]), 1);
        chk("hold_moving", 0, int'(mov_w[0]), 0);

        // Down ramp with wrap.
        async_reset();
        wraps = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(dn_seq[i]), 1'b0);
            wraps += int'(wrap_w[0]);
        end
        chk("dn_wraps", 0, wraps, 1);
        chk("dn_dir", 0, int'(dir_w[0]), 0);
        chk("dn_err", 0, int'(err_w[0]), 0);

        // Counter reset versus illegal jump.
        async_reset();
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        chk("zr_rst_seen", 0, int'(rseen_w[0]), 1);
        chk("zr_locked", 0, int'(lock_w[0]), 0);
        chk("zr_err", 0, int'(err_w[0]), 0);
        chk("nozr_cnt", 1, int'(ecnt_w[1]), 1);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        chk("jump_err", 0, int'(err_w[0]), 1);
        chk("jump_cnt", 0, int'(ecnt_w[0]), 1);
        chk("jump_run", 0, int'(run_w[0]), 1);
        chk("nozr_cnt2", 1, int'(ecnt_w[1]), 2);

        // Clear alone, then clear colliding with a jump.
        step(1'b1, 4'd4, 1'b0);
        step(1'b1, 4'd11, 1'b0);
        chk("pre_clr_cnt", 0, int'(ecnt_w[0]), 3);
        step(1'b1, 4'd11, 1'b1);
        chk("clr_err", 0, int'(err_w[0]), 0);
        chk("clr_cnt", 0, int'(ecnt_w[0]), 0);
        step(1'b1, 4'd4, 1'b0);
        step(1'b1, 4'd11, 1'b1);
        chk("collide_err", 0, int'(err_w[0]), 1);
        chk("collide_cnt", 0, int'(ecnt_w[0]), 1);

        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 4'd4 : 4'd11, 1'b0);
        chk("sat_cnt", 0, int'(ecnt_w[0]), 255);
        chk("sat_cnt", 1, int'(ecnt_w[1]), 255);

        // Valid gap, then reset mid-ramp.
        async_reset();
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd9, 1'b0);
        step(1'b1, 4'd4, 1'b0);
        chk("gap_err", 0, int'(err_w[0]), 0);
        chk("gap_run", 0, int'(run_w[0]), 3);
        step(1'b1, 4'd5, 1'b0);
        async_reset();
        step(1'b1, 4'd12, 1'b0);
        chk("post_rst_err", 0, int'(err_w[0]), 0);
        chk("post_rst_run", 0, int'(run_w[0]), 1);

        // Randomised mix of steps, holds, zeros, jumps, gaps, clears and resets.
        last_d = 4'd12;
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [3:0] nd;
            r = int'($urandom_range(0, 99));
            if (r < 30)      nd = last_d + 4'd1;
            else if (r < 55) nd = last_d - 4'd1;
            else if (r < 75) nd = last_d;
            else if (r < 85) nd = 4'd0;
            else             nd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) != 0) begin
                step(1'b1, nd, ($urandom_range(0, 19) == 0));
                last_d = nd;
            end else begin
                step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
            end
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        step(1'b0, 4'd0, 1'b0);
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
